// File: rtl/intersection_pkg.sv
// Shared types for the intersection controller: phase encodings, the
// previous-phase tag that steers the all-red exit, and lamp vectors.
// Lamp vector bit order: {main_red, main_yellow, main_green,
//                         side_red, side_yellow, side_green, walk}.
package intersection_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED     = 3'd2,
    WALK        = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    PREV_MAIN = 2'd0,
    PREV_WALK = 2'd1,
    PREV_SIDE = 2'd2
  } prev_t;

  typedef logic [6:0] lamp_t;

  localparam lamp_t LAMP_MAIN_GREEN  = 7'b001_100_0;
  localparam lamp_t LAMP_MAIN_YELLOW = 7'b010_100_0;
  localparam lamp_t LAMP_ALL_RED     = 7'b100_100_0;
  localparam lamp_t LAMP_WALK        = 7'b100_100_1;
  localparam lamp_t LAMP_SIDE_GREEN  = 7'b100_001_0;
  localparam lamp_t LAMP_SIDE_YELLOW = 7'b100_010_0;

  function automatic lamp_t lamp_decode(input state_t s);
    case (s)
      MAIN_GREEN:  return LAMP_MAIN_GREEN;
      MAIN_YELLOW: return LAMP_MAIN_YELLOW;
      WALK:        return LAMP_WALK;
      SIDE_GREEN:  return LAMP_SIDE_GREEN;
      SIDE_YELLOW: return LAMP_SIDE_YELLOW;
      default:     return LAMP_ALL_RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase timer: counts cycles spent in the current controller phase.
// Clears to zero on request, otherwise counts up and sticks at all-ones.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  // Saturating up-counter with synchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= '0;
    else if (clear)
      count <= '0;
    else if (enable && (count != '1))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/intersection_controller.sv
// Intersection controller: main road rests on green, side-road and
// pedestrian requests are latched and served with min/max green, yellow
// and all-red clearance timing. Lamp outputs are registered decodes of
// the phase register.
// Build option: PED_WALK_EN enables the pedestrian WALK phase; when it
// is undefined ped_req is ignored and walk/ped_ack stay low.
module intersection_controller
  import intersection_pkg::*;
#(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 8,
  parameter int YELLOW_T  = 2,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 3,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic side_req,
  input  logic ped_req,
  output logic main_red,
  output logic main_yellow,
  output logic main_green,
  output logic side_red,
  output logic side_yellow,
  output logic side_green,
  output logic walk,
  output logic ped_ack
);

  // Last-cycle timer values for each dwell (a dwell of D ends at D-1).
  localparam logic [CNT_W-1:0] T_GMIN = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] T_GMAX = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] T_Y    = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] T_AR   = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] T_W    = CNT_W'(WALK_T - 1);

  state_t           state, state_nxt;
  prev_t            prev;
  logic [CNT_W-1:0] timer;
  logic             side_pend, ped_pend;
  lamp_t            lamps;
  logic             side_clr, ped_clr, ped_set;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_nxt != state),
    .enable (1'b1),
    .count  (timer)
  );

  // Next-phase selection from timer, latched requests and live side sensor.
  always_comb begin
    state_nxt = state;
    case (state)
      MAIN_GREEN:
        if ((timer >= T_GMIN) && (side_pend || ped_pend || side_req))
          state_nxt = MAIN_YELLOW;
      MAIN_YELLOW:
        if (timer == T_Y) state_nxt = ALL_RED;
      ALL_RED:
        if (timer == T_AR) begin
          case (prev)
            PREV_MAIN: state_nxt = ped_pend ? WALK : SIDE_GREEN;
            PREV_WALK: state_nxt = (side_pend || side_req) ? SIDE_GREEN : MAIN_GREEN;
            default:   state_nxt = MAIN_GREEN;
          endcase
        end
      WALK:
        if (timer == T_W) state_nxt = ALL_RED;
      SIDE_GREEN:
        if ((timer == T_GMAX) || ((timer >= T_GMIN) && !side_req))
          state_nxt = SIDE_YELLOW;
      SIDE_YELLOW:
        if (timer == T_Y) state_nxt = ALL_RED;
      default:
        state_nxt = ALL_RED;
    endcase
  end

  assign side_clr = (state_nxt == SIDE_GREEN) && (state != SIDE_GREEN);
  assign ped_clr  = (state_nxt == WALK) && (state != WALK);

`ifdef PED_WALK_EN
  assign ped_set = ped_req && (state != WALK) && !ped_pend;
`else
  logic unused_ped;
  assign ped_set    = 1'b0;
  assign unused_ped = ped_req;
`endif

  // Phase register, previous-phase tag, request latches and lamp outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ALL_RED;
      prev      <= PREV_SIDE;
      side_pend <= 1'b0;
      ped_pend  <= 1'b0;
      ped_ack   <= 1'b0;
      lamps     <= LAMP_ALL_RED;
    end else begin
      state <= state_nxt;
      lamps <= lamp_decode(state_nxt);
      if ((state_nxt == ALL_RED) && (state != ALL_RED)) begin
        case (state)
          MAIN_YELLOW: prev <= PREV_MAIN;
          WALK:        prev <= PREV_WALK;
          default:     prev <= PREV_SIDE;
        endcase
      end
      if (side_clr)
        side_pend <= 1'b0;
      else if (side_req && (state != SIDE_GREEN))
        side_pend <= 1'b1;
      // Clear wins over a same-cycle set; ack only on a real 0->1 latch.
      if (ped_clr)
        ped_pend <= 1'b0;
      else if (ped_set)
        ped_pend <= 1'b1;
      ped_ack <= ped_set && !ped_clr;
    end
  end

  assign {main_red, main_yellow, main_green,
          side_red, side_yellow, side_green, walk} = lamps;

endmodule

// File: tb/tb_intersection_controller.sv
// Testbench for intersection_controller: directed phase-length checks
// plus randomized requests compared each cycle against a phase-level model.
module tb_intersection_controller;

  localparam int GREEN_MIN = 4;
  localparam int GREEN_MAX = 8;
  localparam int YELLOW_T  = 2;
  localparam int ALLRED_T  = 1;
  localparam int WALK_T    = 3;
  localparam int CNT_W     = 8;

`ifdef PED_WALK_EN
  localparam bit PED_EN = 1'b1;
`else
  localparam bit PED_EN = 1'b0;
`endif

  // {main r,y,g, side r,y,g, walk}
  localparam logic [6:0] L_MG = 7'b0011000;
  localparam logic [6:0] L_MY = 7'b0101000;
  localparam logic [6:0] L_AR = 7'b1001000;
  localparam logic [6:0] L_WK = 7'b1001001;
  localparam logic [6:0] L_SG = 7'b1000010;
  localparam logic [6:0] L_SY = 7'b1000100;

  localparam int P_MG = 0, P_MY = 1, P_AR = 2, P_WK = 3, P_SG = 4, P_SY = 5;
  localparam int F_MAIN = 0, F_WALK = 1, F_SIDE = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic side_req = 1'b0;
  logic ped_req = 1'b0;
  logic main_red, main_yellow, main_green, side_red, side_yellow, side_green, walk, ped_ack;
  logic [6:0] lamps;

  int n_chk = 0;
  int n_fail = 0;
  int n_ack = 0;

  intersection_controller #(
    .GREEN_MIN(GREEN_MIN), .GREEN_MAX(GREEN_MAX), .YELLOW_T(YELLOW_T),
    .ALLRED_T(ALLRED_T), .WALK_T(WALK_T), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .side_req(side_req), .ped_req(ped_req),
    .main_red(main_red), .main_yellow(main_yellow), .main_green(main_green),
    .side_red(side_red), .side_yellow(side_yellow), .side_green(side_green),
    .walk(walk), .ped_ack(ped_ack)
  );

  assign lamps = {main_red, main_yellow, main_green, side_red, side_yellow, side_green, walk};

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_ph = P_AR, m_el = 0, m_from = F_SIDE;
  bit m_side = 1'b0, m_ped = 1'b0, m_ack = 1'b0;
  int n_ph, n_el, n_from, done;
  bit n_side, n_ped, n_ack_m;

  function automatic logic [6:0] lamps_of(input int p);
    case (p)
      P_MG:    return L_MG;
      P_MY:    return L_MY;
      P_WK:    return L_WK;
      P_SG:    return L_SG;
      P_SY:    return L_SY;
      default: return L_AR;
    endcase
  endfunction

  always_comb begin
    done    = m_el + 1;
    n_ph    = m_ph;
    n_from  = m_from;
    n_side  = m_side;
    n_ped   = m_ped;
    n_ack_m = 1'b0;
    case (m_ph)
      P_MG: if (done >= GREEN_MIN && (m_side || m_ped || side_req)) n_ph = P_MY;
      P_MY: if (done >= YELLOW_T) n_ph = P_AR;
      P_AR: if (done >= ALLRED_T) begin
              if (m_from == F_MAIN)      n_ph = m_ped ? P_WK : P_SG;
              else if (m_from == F_WALK) n_ph = (m_side || side_req) ? P_SG : P_MG;
              else                       n_ph = P_MG;
            end
      P_WK: if (done >= WALK_T) n_ph = P_AR;
      P_SG: if (done >= GREEN_MAX || (done >= GREEN_MIN && !side_req)) n_ph = P_SY;
      P_SY: if (done >= YELLOW_T) n_ph = P_AR;
      default: n_ph = P_AR;
    endcase
    n_ack_m = PED_EN && ped_req && (m_ph != P_WK) && !m_ped && (n_ph != P_WK);
    if (n_ph == P_SG && m_ph != P_SG)  n_side = 1'b0;
    else if (side_req && m_ph != P_SG) n_side = 1'b1;
    if (n_ph == P_WK && m_ph != P_WK)  n_ped = 1'b0;
    else if (n_ack_m)                  n_ped = 1'b1;
    if (n_ph == P_AR && m_ph != P_AR)
      n_from = (m_ph == P_MY) ? F_MAIN : (m_ph == P_WK) ? F_WALK : F_SIDE;
    n_el = (n_ph == m_ph) ? m_el + 1 : 0;
  end

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_ph <= P_AR; m_el <= 0; m_from <= F_SIDE;
      m_side <= 1'b0; m_ped <= 1'b0; m_ack <= 1'b0;
    end else begin
      m_ph <= n_ph; m_el <= n_el; m_from <= n_from;
      m_side <= n_side; m_ped <= n_ped; m_ack <= n_ack_m;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (ped_ack) n_ack++;
    n_chk++;
    if (reset) begin
      if (lamps !== L_AR || ped_ack !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: lamps=%b ack=%b, required lamps=%b ack=0", lamps, ped_ack, L_AR);
      end
    end else begin
      if (lamps !== lamps_of(m_ph) || ped_ack !== m_ack) begin
        n_fail++;
        $display("FAIL model_compare t=%0t: lamps=%b ack=%b, required lamps=%b ack=%b",
                 $time, lamps, ped_ack, lamps_of(m_ph), m_ack);
      end
    end
    n_chk++;
    if (((main_green || main_yellow) && (side_green || side_yellow)) ||
        (walk && (main_green || main_yellow || side_green || side_yellow))) begin
      n_fail++;
      $display("FAIL safety: lamps=%b, required no conflicting non-red lamps", lamps);
    end
  end

  // ---------------- directed helpers ----------------
  // Called at a negedge: waits for a phase, then measures how many cycles it lasts.
  task automatic expect_run(input logic [6:0] want, input int len, input string name);
    int waited = 0;
    int cnt = 0;
    while (lamps !== want && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    n_chk++;
    if (lamps !== want) begin
      n_fail++;
      $display("FAIL %s_reach: lamps=%b, required %b within 200 cycles", name, lamps, want);
      return;
    end
    while (lamps === want && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    n_chk++;
    if (cnt != len) begin
      n_fail++;
      $display("FAIL %s_len: lasted %0d cycles, required %0d", name, cnt, len);
    end
  endtask

  task automatic check_lamps(input logic [6:0] want, input string name);
    n_chk++;
    if (lamps !== want) begin
      n_fail++;
      $display("FAIL %s: lamps=%b, required %b", name, lamps, want);
    end
  endtask

  task automatic tick_drive(input logic s, input logic p);
    @(posedge clk);
    #1;
    side_req = s;
    ped_req  = p;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int ack0;
    int waited;
    // Reset release: ALL_RED for one cycle, then MAIN_GREEN rests.
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_lamps(L_AR, "post_reset_allred");
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check_lamps(L_MG, "idle_main_green");
    end

    // One-cycle side pulse.
    tick_drive(1'b1, 1'b0);
    tick_drive(1'b0, 1'b0);
    @(negedge clk);
    expect_run(L_MY, 2, "pulse_my");
    expect_run(L_AR, 1, "pulse_ar1");
    expect_run(L_SG, 4, "pulse_sg");
    expect_run(L_SY, 2, "pulse_sy");
    expect_run(L_AR, 1, "pulse_ar2");

    // Side held high from MAIN_GREEN cycle 1: max green, then back via a min main green.
    tick_drive(1'b1, 1'b0);
    @(negedge clk);
    expect_run(L_MY, 2, "hold_my");
    expect_run(L_AR, 1, "hold_ar1");
    expect_run(L_SG, 8, "hold_sg_max");
    expect_run(L_SY, 2, "hold_sy");
    expect_run(L_AR, 1, "hold_ar2");
    expect_run(L_MG, 4, "hold_mg_min");
    tick_drive(1'b0, 1'b0);
    @(negedge clk);
    expect_run(L_AR, 1, "hold_ar3");
    expect_run(L_SG, 4, "hold_sg_min");
    expect_run(L_SY, 2, "hold_sy2");
    expect_run(L_AR, 1, "hold_ar4");

    // Pedestrian and side requests in the same cycle.
    ack0 = n_ack;
`ifdef PED_WALK_EN
    tick_drive(1'b1, 1'b1);
    tick_drive(1'b0, 1'b0);
    @(negedge clk);
    expect_run(L_MY, 2, "ped_my");
    expect_run(L_AR, 1, "ped_ar1");
    expect_run(L_WK, 3, "ped_walk");
    expect_run(L_AR, 1, "ped_ar2");
    expect_run(L_SG, 4, "ped_sg");
    expect_run(L_SY, 2, "ped_sy");
    expect_run(L_AR, 1, "ped_ar3");
    n_chk++;
    if (n_ack - ack0 != 1) begin
      n_fail++;
      $display("FAIL ped_ack_count: saw %0d pulses, required 1", n_ack - ack0);
    end
`else
    tick_drive(1'b0, 1'b1);
    tick_drive(1'b0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check_lamps(L_MG, "ped_disabled_hold");
    end
    n_chk++;
    if (n_ack != ack0) begin
      n_fail++;
      $display("FAIL ped_ack_disabled: saw %0d pulses, required 0", n_ack - ack0);
    end
`endif

    // Reset in the middle of SIDE_GREEN.
    tick_drive(1'b1, 1'b0);
    tick_drive(1'b0, 1'b0);
    waited = 0;
    @(negedge clk);
    while (lamps !== L_SG && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check_lamps(L_SG, "pre_reset_side_green");
    @(posedge clk);
    #3 reset = 1'b1;
    #1 check_lamps(L_AR, "async_reset_allred");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_lamps(L_AR, "reset2_allred");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_lamps(L_MG, "reset2_no_side");
    end

    // Randomized traffic, checked each cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 499) == 0) reset = 1'b1;
      if ($urandom_range(0, 5) == 0) side_req = ~side_req;
      ped_req = ($urandom_range(0, 24) == 0);
    end
    side_req = 1'b0;
    ped_req  = 1'b0;
    reset    = 1'b0;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
